// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the CPU trace record parser.
// States, record format codes, error bit positions and ASCII tokens.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_TIME       = 4'd1,
        S_PC         = 4'd2,
        S_AFTER_PC   = 4'd3,
        S_REG        = 4'd4,
        S_ADDR       = 4'd5,
        S_BEFORE_ASN = 4'd6,
        S_ASN_LT     = 4'd7,
        S_AFTER_ASN  = 4'd8,
        S_DATA       = 4'd9,
        S_FINISH     = 4'd10
    } state_e;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam int ERR_PC   = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_REG  = 2;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    // Per-character datapath actions chosen by the next-state logic.
    typedef struct packed {
        logic clr;
        logic acc_time;
        logic acc_pc;
        logic acc_reg;
        logic acc_addr;
        logic acc_data;
        logic set_reg;
        logic set_mem;
    } act_t;

endpackage

// File: rtl/cpu_record_parser_classify.sv
// ASCII digit classifier: decimal/hex flags and the digit's nibble value.
// Letters map via their low nibble: 'a'/'A' = x1, so value = low nibble + 9.
module char_classify #(
    parameter int ALLOW_UPPER = 0
) (
    input  logic [7:0] ch,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    logic lo_hex;
    logic up_hex;

    always_comb begin
        is_dec = (ch >= 8'h30) && (ch <= 8'h39);
        lo_hex = (ch >= 8'h61) && (ch <= 8'h66);
        up_hex = (ALLOW_UPPER != 0) && (ch >= 8'h41) && (ch <= 8'h46);
        is_hex = is_dec | lo_hex | up_hex;
        nibble = 4'd0;
        unique case (1'b1)
            is_dec:          nibble = ch[3:0];
            lo_hex | up_hex: nibble = ch[3:0] + 4'd9;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_record_parser.sv
// Streaming parser/checker for "^time@pc: $reg <= data#" and
// "^time@pc: *addr <= data#" trace records, one char per accepted cycle.
module cpu_record_parser
    import cpu_trace_pkg::*;
#(
    parameter int TIME_DIGITS_MAX = 4,
    parameter int REG_DIGITS_MAX  = 4,
    parameter int ADDR_DIGITS     = 8,
    parameter int ALLOW_UPPER     = 0,
    parameter logic [4*ADDR_DIGITS-1:0] PC_MIN   = 32'h00003000,
    parameter logic [4*ADDR_DIGITS-1:0] PC_MAX   = 32'h00006ffc,
    parameter logic [4*ADDR_DIGITS-1:0] ADDR_MAX = 32'h00002ffc
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         char_valid,
    input  logic [7:0]                   char,
    output logic [1:0]                   format_type,
    output logic [2:0]                   error_code,
    output logic [4*TIME_DIGITS_MAX-1:0] time_val,
    output logic [4*ADDR_DIGITS-1:0]     pc_val,
    output logic [4*REG_DIGITS_MAX-1:0]  reg_num,
    output logic [4*ADDR_DIGITS-1:0]     addr_val,
    output logic [4*ADDR_DIGITS-1:0]     data_val,
    output logic [3:0]                   state
);

    localparam int TW  = 4 * TIME_DIGITS_MAX;
    localparam int RW  = 4 * REG_DIGITS_MAX;
    localparam int AW  = 4 * ADDR_DIGITS;
    localparam int TCW = $clog2(TIME_DIGITS_MAX + 1);
    localparam int RCW = $clog2(REG_DIGITS_MAX + 1);
    localparam int ACW = $clog2(ADDR_DIGITS + 1);

    logic       is_dec;
    logic       is_hex;
    logic [3:0] nib;

    char_classify #(
        .ALLOW_UPPER(ALLOW_UPPER)
    ) u_classify (
        .ch    (char),
        .is_dec(is_dec),
        .is_hex(is_hex),
        .nibble(nib)
    );

    state_e         state_q;
    state_e         state_d;
    act_t           act;
    logic [1:0]     fmt_q;
    logic [TCW-1:0] time_cnt;
    logic [RCW-1:0] reg_cnt;
    logic [ACW-1:0] pc_cnt;
    logic [ACW-1:0] addr_cnt;
    logic [ACW-1:0] data_cnt;

    logic time_room;
    logic reg_room;
    logic pc_room;
    logic addr_room;
    logic data_room;
    logic is_sp;
    logic is_lt;

    assign time_room = time_cnt < TCW'(TIME_DIGITS_MAX);
    assign reg_room  = reg_cnt < RCW'(REG_DIGITS_MAX);
    assign pc_room   = pc_cnt < ACW'(ADDR_DIGITS);
    assign addr_room = addr_cnt < ACW'(ADDR_DIGITS);
    assign data_room = data_cnt < ACW'(ADDR_DIGITS);
    assign is_sp     = char == CH_SPACE;
    assign is_lt     = char == CH_LT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Anything not explicitly accepted drops to IDLE; '^' restarts from any state.
    always_comb begin
        state_d = state_q;
        act     = '0;
        if (char_valid) begin
            state_d = S_IDLE;
            if (char == CH_CARET) begin
                state_d = S_TIME;
                act.clr = 1'b1;
            end else begin
                unique case (state_q)
                    S_TIME: begin
                        if (is_dec && time_room) begin
                            state_d      = S_TIME;
                            act.acc_time = 1'b1;
                        end else if (char == CH_AT && time_cnt != '0) begin
                            state_d = S_PC;
                        end
                    end
                    S_PC: begin
                        if (is_hex && pc_room) begin
                            state_d    = S_PC;
                            act.acc_pc = 1'b1;
                        end else if (char == CH_COLON && !pc_room) begin
                            state_d = S_AFTER_PC;
                        end
                    end
                    S_AFTER_PC: begin
                        if (is_sp) begin
                            state_d = S_AFTER_PC;
                        end else if (char == CH_DOLLAR) begin
                            state_d     = S_REG;
                            act.set_reg = 1'b1;
                        end else if (char == CH_STAR) begin
                            state_d     = S_ADDR;
                            act.set_mem = 1'b1;
                        end
                    end
                    S_REG: begin
                        if (is_dec && reg_room) begin
                            state_d     = S_REG;
                            act.acc_reg = 1'b1;
                        end else if (is_sp && reg_cnt == '0) begin
                            state_d = S_REG;
                        end else if (is_sp) begin
                            state_d = S_BEFORE_ASN;
                        end else if (is_lt && reg_cnt != '0) begin
                            state_d = S_ASN_LT;
                        end
                    end
                    S_ADDR: begin
                        if (is_hex && addr_room) begin
                            state_d      = S_ADDR;
                            act.acc_addr = 1'b1;
                        end else if (is_sp && addr_cnt == '0) begin
                            state_d = S_ADDR;
                        end else if (is_sp && !addr_room) begin
                            state_d = S_BEFORE_ASN;
                        end else if (is_lt && !addr_room) begin
                            state_d = S_ASN_LT;
                        end
                    end
                    S_BEFORE_ASN: begin
                        if (is_sp) begin
                            state_d = S_BEFORE_ASN;
                        end else if (is_lt) begin
                            state_d = S_ASN_LT;
                        end
                    end
                    S_ASN_LT: begin
                        if (char == CH_EQ) begin
                            state_d = S_AFTER_ASN;
                        end
                    end
                    S_AFTER_ASN: begin
                        if (is_sp) begin
                            state_d = S_AFTER_ASN;
                        end else if (is_hex) begin
                            state_d      = S_DATA;
                            act.acc_data = 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (is_hex && data_room) begin
                            state_d      = S_DATA;
                            act.acc_data = 1'b1;
                        end else if (char == CH_HASH && !data_room) begin
                            state_d = S_FINISH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmt_q    <= FMT_NONE;
            time_val <= '0;
            pc_val   <= '0;
            reg_num  <= '0;
            addr_val <= '0;
            data_val <= '0;
            time_cnt <= '0;
            reg_cnt  <= '0;
            pc_cnt   <= '0;
            addr_cnt <= '0;
            data_cnt <= '0;
        end else if (act.clr) begin
            fmt_q    <= FMT_NONE;
            time_val <= '0;
            pc_val   <= '0;
            reg_num  <= '0;
            addr_val <= '0;
            data_val <= '0;
            time_cnt <= '0;
            reg_cnt  <= '0;
            pc_cnt   <= '0;
            addr_cnt <= '0;
            data_cnt <= '0;
        end else begin
            if (act.acc_time) begin
                time_val <= time_val * TW'(10) + TW'(nib);
                time_cnt <= time_cnt + TCW'(1);
            end
            if (act.acc_pc) begin
                pc_val <= {pc_val[AW-5:0], nib};
                pc_cnt <= pc_cnt + ACW'(1);
            end
            if (act.acc_reg) begin
                reg_num <= reg_num * RW'(10) + RW'(nib);
                reg_cnt <= reg_cnt + RCW'(1);
            end
            if (act.acc_addr) begin
                addr_val <= {addr_val[AW-5:0], nib};
                addr_cnt <= addr_cnt + ACW'(1);
            end
            if (act.acc_data) begin
                data_val <= {data_val[AW-5:0], nib};
                data_cnt <= data_cnt + ACW'(1);
            end
            if (act.set_reg) begin
                fmt_q <= FMT_REG;
            end
            if (act.set_mem) begin
                fmt_q <= FMT_MEM;
            end
        end
    end

    logic pc_bad;
    logic addr_bad;
    logic reg_bad;

    assign pc_bad   = (pc_val < PC_MIN) || (pc_val > PC_MAX)
                    || (pc_val[1:0] != 2'b00);
    assign addr_bad = (addr_val > ADDR_MAX) || (addr_val[1:0] != 2'b00);
    assign reg_bad  = reg_num > RW'(31);

    always_comb begin
        format_type = FMT_NONE;
        error_code  = '0;
        if (state_q == S_FINISH) begin
            format_type          = fmt_q;
            error_code[ERR_PC]   = pc_bad;
            error_code[ERR_ADDR] = (fmt_q == FMT_MEM) && addr_bad;
            error_code[ERR_REG]  = (fmt_q == FMT_REG) && reg_bad;
        end
    end

    assign state = state_q;

endmodule
